// File: rtl/store_unit_pkg.sv
// store_unit_pkg: shared constants for the store path.
// Contents:
//   - funct3 encodings for the store opcodes.
//   - byte-enable size masks.
//   - FSM state enum.
//   - beat_t: one memory beat's lane data.
//   - sizeMask(): maps funct3 to a size mask (0 = illegal encoding).
package store_unit_pkg;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  localparam logic [3:0] MASK_B = 4'b0001;
  localparam logic [3:0] MASK_H = 4'b0011;
  localparam logic [3:0] MASK_W = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BEAT0,
    ST_BEAT1,
    ST_FIN
  } state_t;

  typedef struct packed {
    logic [3:0]  be;
    logic [31:0] data;
  } beat_t;

  // A zero mask doubles as the "illegal funct3" marker.
  function automatic logic [3:0] sizeMask(input logic [2:0] funct3);
    case (funct3)
      F3_SB:   return MASK_B;
      F3_SH:   return MASK_H;
      F3_SW:   return MASK_W;
      default: return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/store_unit_if.sv
// store_unit_if: request and memory-write bundle for the store unit.
// Signals:
//   - Request side: req_valid, req_ready, req_addr, req_wdata, req_funct3,
//     done, err.
//   - Memory side: mem_we, mem_addr, mem_wdata, mem_be, mem_ack.
// Modports:
//   - slave:  the store unit itself.
//   - master: the environment, i.e. the execute stage plus data memory.
interface store_unit_if #(parameter int ADDR_W = 32);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic [2:0]        req_funct3;
  logic              done;
  logic              err;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_be;
  logic              mem_ack;

  modport slave (
    input  req_valid, req_addr, req_wdata, req_funct3, mem_ack,
    output req_ready, done, err, mem_we, mem_addr, mem_wdata, mem_be
  );

  modport master (
    output req_valid, req_addr, req_wdata, req_funct3, mem_ack,
    input  req_ready, done, err, mem_we, mem_addr, mem_wdata, mem_be
  );
endinterface

// File: rtl/store_lane_align.sv
// store_lane_align: combinational byte-lane alignment.
// Ports:
//   - off:     byte offset within the word.
//   - funct3:  access size encoding.
//   - wdata:   unaligned register data.
//   - be8:     byte enables across two consecutive words
//              (low nibble = first word).
//   - data64:  write data aligned to those lanes.
//   - split:   access spills into the second word.
//   - illegal: funct3 is not a store size.
// The load path reuses this block for mask generation.
module store_lane_align
  import store_unit_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  output logic [7:0]  be8,
  output logic [63:0] data64,
  output logic        split,
  output logic        illegal
);
  logic [3:0] mask;

  always_comb begin
    mask    = sizeMask(funct3);
    illegal = (mask == 4'b0000);
    be8     = {4'b0000, mask} << off;
    data64  = {32'b0, wdata} << {off, 3'b000};
    split   = |be8[7:4];
  end
endmodule

// File: rtl/store_unit.sv
// store_unit: narrows and aligns register data into word-aligned memory
// writes.
// Ports:
//   - clk, reset: clock and synchronous active-high reset.
//   - bus:        store_unit_if.slave, carrying the request handshake and
//                 the memory write port.
// Stores that cross a word boundary go out as two beats when
// ALLOW_MISALIGNED=1. When ALLOW_MISALIGNED=0 they complete with err and
// no memory write. All outputs are registered.
module store_unit
  import store_unit_pkg::*;
#(
  parameter int ADDR_W           = 32,
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  store_unit_if.slave bus
);
  state_t            state;
  beat_t             beat1;
  logic [ADDR_W-1:0] beat1Addr;
  logic              isSplit;

  logic [7:0]        be8;
  logic [63:0]       data64;
  logic              split;
  logic              illegal;
  logic [ADDR_W-1:0] baseAddr;

  assign baseAddr = {bus.req_addr[ADDR_W-1:2], 2'b00};

  store_lane_align uAlign (
    .off    (bus.req_addr[1:0]),
    .funct3 (bus.req_funct3),
    .wdata  (bus.req_wdata),
    .be8    (be8),
    .data64 (data64),
    .split  (split),
    .illegal(illegal)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      bus.req_ready <= 1'b1;
      bus.done      <= 1'b0;
      bus.err       <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mem_be    <= '0;
      beat1         <= '0;
      beat1Addr     <= '0;
      isSplit       <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            bus.req_ready <= 1'b0;
            beat1         <= '{be: be8[7:4], data: data64[63:32]};
            beat1Addr     <= baseAddr + ADDR_W'(4);  // wraps at top of space
            isSplit       <= split;
            if (illegal || (split && !ALLOW_MISALIGNED)) begin
              state    <= ST_FIN;
              bus.done <= 1'b1;
              bus.err  <= 1'b1;
            end else begin
              state         <= ST_BEAT0;
              bus.err       <= 1'b0;
              bus.mem_we    <= 1'b1;
              bus.mem_addr  <= baseAddr;
              bus.mem_be    <= be8[3:0];
              bus.mem_wdata <= data64[31:0];
            end
          end
        end
        ST_BEAT0: begin
          if (bus.mem_ack) begin
            if (isSplit) begin
              state         <= ST_BEAT1;
              bus.mem_addr  <= beat1Addr;
              bus.mem_be    <= beat1.be;
              bus.mem_wdata <= beat1.data;
            end else begin
              state         <= ST_FIN;
              bus.done      <= 1'b1;
              bus.mem_we    <= 1'b0;
              bus.mem_be    <= '0;
              bus.mem_wdata <= '0;
            end
          end
        end
        ST_BEAT1: begin
          if (bus.mem_ack) begin
            state         <= ST_FIN;
            bus.done      <= 1'b1;
            bus.mem_we    <= 1'b0;
            bus.mem_be    <= '0;
            bus.mem_wdata <= '0;
          end
        end
        ST_FIN: begin
          // done was raised on entry; this cycle it drops and we reopen.
          state         <= ST_IDLE;
          bus.req_ready <= 1'b1;
          bus.err       <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_store_unit.sv
module tb_store_unit;
  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  store_unit_if #(.ADDR_W(32)) ifA ();
  store_unit_if #(.ADDR_W(32)) ifB ();

  store_unit #(.ADDR_W(32), .ALLOW_MISALIGNED(1'b1)) dutA (
    .clk(clk), .reset(reset), .bus(ifA)
  );
  store_unit #(.ADDR_W(32), .ALLOW_MISALIGNED(1'b0)) dutB (
    .clk(clk), .reset(reset), .bus(ifB)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reqA(input logic [31:0] addr, input logic [31:0] wdata, input logic [2:0] f3);
    ifA.req_valid  = 1'b1;
    ifA.req_addr   = addr;
    ifA.req_wdata  = wdata;
    ifA.req_funct3 = f3;
  endtask

  task automatic beatA(input string tag, input logic [31:0] addr, input logic [3:0] be,
                       input logic [31:0] data);
    chk({tag, ".we"},   ifA.mem_we,    1'b1);
    chk({tag, ".addr"}, ifA.mem_addr,  addr);
    chk({tag, ".be"},   ifA.mem_be,    be);
    chk({tag, ".data"}, ifA.mem_wdata, data);
    chk({tag, ".done"}, ifA.done,      1'b0);
  endtask

  task automatic finA(input string tag, input logic e);
    chk({tag, ".done"}, ifA.done,      1'b1);
    chk({tag, ".err"},  ifA.err,       e);
    chk({tag, ".we"},   ifA.mem_we,    1'b0);
    chk({tag, ".be"},   ifA.mem_be,    4'h0);
    chk({tag, ".rdy"},  ifA.req_ready, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    ifA.req_valid = 1'b0; ifA.req_addr = '0; ifA.req_wdata = '0; ifA.req_funct3 = '0;
    ifA.mem_ack = 1'b1;
    ifB.req_valid = 1'b0; ifB.req_addr = '0; ifB.req_wdata = '0; ifB.req_funct3 = '0;
    ifB.mem_ack = 1'b1;
    tick(); tick();

    // Reset state
    chk("rst.rdy",  ifA.req_ready, 1'b1);
    chk("rst.done", ifA.done,      1'b0);
    chk("rst.err",  ifA.err,       1'b0);
    chk("rst.we",   ifA.mem_we,    1'b0);
    chk("rst.addr", ifA.mem_addr,  32'h0);
    chk("rst.data", ifA.mem_wdata, 32'h0);
    chk("rst.be",   ifA.mem_be,    4'h0);
    reset = 1'b0;
    tick();

    // SW aligned, done two cycles after accept
    reqA(32'h100, 32'hDEADBEEF, 3'b010);
    tick(); ifA.req_valid = 1'b0;
    beatA("sw", 32'h100, 4'b1111, 32'hDEADBEEF);
    tick(); finA("sw.fin", 1'b0);
    tick();
    chk("sw.idle.rdy",  ifA.req_ready, 1'b1);
    chk("sw.idle.done", ifA.done,      1'b0);

    // SB at offset 3
    reqA(32'h203, 32'h000000A5, 3'b000);
    tick(); ifA.req_valid = 1'b0;
    beatA("sb", 32'h200, 4'b1000, 32'hA5000000);
    tick(); finA("sb.fin", 1'b0);
    tick();

    // SH at offset 2 stays in one word
    reqA(32'h102, 32'h0000CAFE, 3'b001);
    tick(); ifA.req_valid = 1'b0;
    beatA("sh2", 32'h100, 4'b1100, 32'hCAFE0000);
    tick(); finA("sh2.fin", 1'b0);
    tick();

    // Misaligned SW: split on A, error on B
    reqA(32'h102, 32'h11223344, 3'b010);
    ifB.req_valid = 1'b1; ifB.req_addr = 32'h102; ifB.req_wdata = 32'h11223344;
    ifB.req_funct3 = 3'b010;
    tick(); ifA.req_valid = 1'b0; ifB.req_valid = 1'b0;
    beatA("swm.b0", 32'h100, 4'b1100, 32'h33440000);
    chk("nomis.done", ifB.done,   1'b1);
    chk("nomis.err",  ifB.err,    1'b1);
    chk("nomis.we",   ifB.mem_we, 1'b0);
    tick();
    beatA("swm.b1", 32'h104, 4'b0011, 32'h00001122);
    chk("nomis.done2", ifB.done,      1'b0);
    chk("nomis.we2",   ifB.mem_we,    1'b0);
    chk("nomis.rdy2",  ifB.req_ready, 1'b1);
    tick(); finA("swm.fin", 1'b0);
    tick();

    // Split across the top of the address space wraps to 0
    reqA(32'hFFFFFFFE, 32'hAABBCCDD, 3'b010);
    tick(); ifA.req_valid = 1'b0;
    beatA("wrap.b0", 32'hFFFFFFFC, 4'b1100, 32'hCCDD0000);
    tick();
    beatA("wrap.b1", 32'h00000000, 4'b0011, 32'h0000AABB);
    tick(); finA("wrap.fin", 1'b0);
    tick();

    // SH offset 3 with ack withheld; req_valid pulses ignored
    ifA.mem_ack = 1'b0;
    reqA(32'h003, 32'h0000BEEF, 3'b001);
    tick();
    for (int i = 0; i < 5; i++) begin
      ifA.req_valid = i[0];
      ifA.req_addr  = 32'h500;
      ifA.req_funct3 = 3'b010;
      beatA($sformatf("stall%0d", i), 32'h000, 4'b1000, 32'hEF000000);
      chk($sformatf("stall%0d.rdy", i), ifA.req_ready, 1'b0);
      tick();
    end
    ifA.req_valid = 1'b0;
    beatA("stall.end", 32'h000, 4'b1000, 32'hEF000000);
    ifA.mem_ack = 1'b1;
    tick();
    beatA("stall.b1", 32'h004, 4'b0001, 32'h000000BE);
    tick(); finA("stall.fin", 1'b0);
    tick();

    // Illegal funct3
    reqA(32'h100, 32'h12345678, 3'b011);
    tick(); ifA.req_valid = 1'b0;
    finA("ill", 1'b1);
    tick();
    chk("ill.idle.err", ifA.err,       1'b0);
    chk("ill.idle.rdy", ifA.req_ready, 1'b1);

    // Reset during a stalled beat1
    reqA(32'h003, 32'h0000BEEF, 3'b001);
    tick(); ifA.req_valid = 1'b0;
    tick(); ifA.mem_ack = 1'b0;
    beatA("rb.b1", 32'h004, 4'b0001, 32'h000000BE);
    tick();
    beatA("rb.hold", 32'h004, 4'b0001, 32'h000000BE);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rb.we",   ifA.mem_we,    1'b0);
    chk("rb.rdy",  ifA.req_ready, 1'b1);
    chk("rb.done", ifA.done,      1'b0);
    chk("rb.be",   ifA.mem_be,    4'h0);
    ifA.mem_ack = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
